ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
EX→MEM pipeline stage that consumes one ALU result per cycle (S, zero, carryout, overflow plus instruction metadata) and holds it for the memory stage. It uses a valid/ready handshake on both sides with a 2-entry skid buffer, so a MEM stall never drops an ALU result. It detects arithmetic-overflow traps on add/sub, kills the offending instruction's side effects, and records the exception PC until the exception is acknowledged.

Parameters:
DATA_W, 32, ALU operand/result width
REG_AW, 5, destination register index width
CNT_W, 8, width of saturating overflow-trap counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all buffered entries (branch/exception redirect)
ex_valid  in  1  EX offers an entry
ex_ready  out  1  stage can accept
ex_alu_ctrl  in  4  ALU control code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR)
ex_s  in  DATA_W  ALU result S
ex_zero  in  1  ALU zero flag
ex_carry  in  1  ALU carryout
ex_ovf  in  1  ALU overflow flag
ex_store_data  in  DATA_W  rt value for stores
ex_rd  in  REG_AW  destination register
ex_reg_write  in  1  writeback enable
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_trap_en  in  1  signed op; overflow traps (ADD/SUB, not ADDU/SUBU)
ex_pc  in  DATA_W  instruction PC
mem_valid  out  1  entry presented to MEM
mem_ready  in  1  MEM accepts
mem_addr_res  out  DATA_W  registered S
mem_zero  out  1  registered zero
mem_carry  out  1  registered carryout
mem_store_data  out  DATA_W  registered store data
mem_rd  out  REG_AW  registered rd
mem_reg_write  out  1  gated writeback enable
mem_mem_read  out  1  gated load
mem_mem_write  out  1  gated store
mem_exc  out  1  this entry trapped
exc_pending  out  1  sticky trap flag
exc_epc  out  DATA_W  PC of first unacknowledged trap
exc_ack  in  1  clears exc_pending
ovf_count  out  CNT_W  saturating count of trapped overflows

Behaviour:
- Reset (rst_n=0 at clk edge): main/skid valid=0; all mem_* outputs 0; exc_pending=0, exc_epc=0, ovf_count=0. ex_ready forced 0 while rst_n=0.
- Trap condition: trap = ex_ovf & ex_trap_en & (ex_alu_ctrl==0010 | ex_alu_ctrl==0110). ex_ovf ignored for all other codes.
- On capture, a trapped entry stores reg_write=0, mem_read=0, mem_write=0, exc=1; S/zero/carry still stored unmodified.
- Handshake: transfer in when ex_valid & ex_ready; out when mem_valid & mem_ready. Payload stable while mem_valid & !mem_ready.
- ex_ready = !skid_valid (registered state, no combinational path from mem_ready).
- Main register: loads when empty or draining (mem_ready). Source is skid if skid valid, else input. If skid drains into main and input accepted same cycle, input goes to skid.
- Skid: loads input when main valid, !mem_ready, input accepted.
- Latency: 1 cycle accept→mem_valid when empty; sustained throughput 1/cycle with mem_ready=1.
- Ordering strictly FIFO; never more than 2 entries.
- flush: at clock edge clears main and skid valid; input offered that cycle is not captured; mem_* payload keeps last value (don't-care). flush does not clear exc_pending, exc_epc or ovf_count.
- exc_pending/exc_epc: set on acceptance of a trapped entry (not on flush-dropped input). If already pending, exc_epc holds first PC (first wins). exc_ack clears pending; simultaneous ack and new trap → pending stays 1, exc_epc = new PC.
- ovf_count: +1 per accepted trapped entry, saturates at all-ones; cleared only by reset.
- Reset mid-operation: buffered entries lost, no transfer completes that edge.

Test Plan:
- ADD ctrl=0010, S=0x8011110E, ovf=1, trap_en=1, pc=0x00400020 → next cycle mem_valid=1, mem_exc=1, mem_reg_write=0, exc_pending=1, exc_epc=0x00400020, ovf_count=1.
- SUB ctrl=0110, S=0xFFFFFFFE, zero=0, reg_write=1, rd=5, mem_ready=1 → mem_addr_res=0xFFFFFFFE, mem_rd=5, mem_reg_write=1, mem_exc=0; SLT ctrl=0111 with ovf=1 → no trap.
- mem_ready=0, three back-to-back entries A,B,C → A and B held, ex_ready=0 after B, C stalls; raise mem_ready → A,B,C emerge in order, none lost or duplicated.
- Two entries buffered, flush=1 with ex_valid=1 → next cycle mem_valid=0, ex_ready=1, input not captured; exc state unchanged.
- exc_pending=1 (epc 0x100), trapped entry pc=0x200 with exc_ack=1 same cycle → exc_pending=1, exc_epc=0x200; without ack → epc stays 0x100; 300 traps → ovf_count=0xFF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer, overflow-trap detection,
// a sticky exception PC and a saturating trap counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_alu_ctrl,
  input  logic [DATA_W-1:0] ex_s,
  input  logic              ex_zero,
  input  logic              ex_carry,
  input  logic              ex_ovf,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_trap_en,
  input  logic [DATA_W-1:0] ex_pc,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_addr_res,
  output logic              mem_zero,
  output logic              mem_carry,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_exc,
  output logic              exc_pending,
  output logic [DATA_W-1:0] exc_epc,
  input  logic              exc_ack,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic              zero;
    logic              carry;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              exc;
  } entry_t;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  entry_t main_q, skid_q, in_entry;
  logic   main_valid, skid_valid;
  logic   trap, accept;

  assign trap   = ex_ovf & ex_trap_en & ((ex_alu_ctrl == CTRL_ADD) | (ex_alu_ctrl == CTRL_SUB));
  // ready depends only on registered state, never on mem_ready
  assign ex_ready = rst_n & ~skid_valid;
  assign accept   = ex_valid & ex_ready & ~flush;

  always_comb begin
    in_entry.s          = ex_s;
    in_entry.zero       = ex_zero;
    in_entry.carry      = ex_carry;
    in_entry.store_data = ex_store_data;
    in_entry.rd         = ex_rd;
    in_entry.reg_write  = ex_reg_write & ~trap;
    in_entry.mem_read   = ex_mem_read & ~trap;
    in_entry.mem_write  = ex_mem_write & ~trap;
    in_entry.exc        = trap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      exc_pending <= 1'b0;
      exc_epc     <= '0;
      ovf_count   <= '0;
    end else begin
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || mem_ready) begin
        if (skid_valid) begin
          // skid full implies ex_ready=0, so no input competes for main here
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= accept;
          if (accept) main_q <= in_entry;
        end
      end else if (accept) begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
      end

      if (accept && trap) begin
        // first unacknowledged trap wins unless the ack retires it this cycle
        if (!exc_pending || exc_ack) exc_epc <= ex_pc;
        exc_pending <= 1'b1;
        if (ovf_count != {CNT_W{1'b1}}) ovf_count <= ovf_count + CNT_W'(1);
      end else if (exc_ack) begin
        exc_pending <= 1'b0;
      end
    end
  end

  assign mem_valid      = main_valid;
  assign mem_addr_res   = main_q.s;
  assign mem_zero       = main_q.zero;
  assign mem_carry      = main_q.carry;
  assign mem_store_data = main_q.store_data;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_exc        = main_q.exc;

endmodule
